i2c_master_byte: RTL and testbench
==================================

I2C_MASTER_BYTE -- requirements
Module: i2c_master_byte

Interface
REQ-001 Parameter: NBITS, 8, number of data bits per byte transfer.
REQ-002 clk  input  1  system clock; the only clock, shared with the I2C clock divider.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 scl_p  input  1  one-cycle strobe from the divider marking each SCL rising edge.
REQ-005 scl_n  input  1  one-cycle strobe from the divider marking each SCL falling edge.
REQ-006 cmd_valid  input  1  command request.
REQ-007 cmd_ready  output  1  high only in IDLE; a command is accepted when cmd_valid and cmd_ready are both 1.
REQ-008 cmd_start, cmd_stop, cmd_read  input  1 each  prefix START, suffix STOP, read (1) or write (0).
REQ-009 cmd_nack  input  1  ACK bit the master sends after a read: 0 = ACK, 1 = NACK.
REQ-010 tx_data  input  NBITS  write byte, sent MSB first.
REQ-011 sda_in  input  1  sampled SDA line.
REQ-012 sda_oe  output  1  1 pulls SDA low; 0 releases SDA.
REQ-013 scl_en  output  1  1 lets the divider clock drive SCL; 0 holds SCL released (high).
REQ-014 rx_data  output  NBITS  read byte; valid when done is 1.
REQ-015 done  output  1  one-cycle pulse when a command completes.
REQ-016 ack_err  output  1  latched with done: slave NACK on a write.
REQ-017 busy  output  1  high whenever the state is not IDLE.

Function
REQ-018 States and transitions:
- IDLE -> START on accept with cmd_start=1.
- IDLE -> DATA on accept with cmd_start=0.
- START -> DATA.
- DATA -> ACK after NBITS bits.
- ACK -> STOP if cmd_stop=1; ACK -> IDLE otherwise.
- STOP -> IDLE.
REQ-019 The block latches all command fields and tx_data on accept; later input changes have no effect until the next accept.
REQ-020 START: at the first scl_p after accept, assert sda_oe (SCL high); at the following scl_n, set scl_en=1 and go to DATA.
REQ-021 DATA, write: update sda_oe = ~bit only at scl_n, MSB first; the first bit is placed on the scl_n that enters DATA, or on the first scl_n after accept when there is no START.
REQ-022 DATA, read: hold sda_oe=0; shift sda_in into rx_data LSB-first-in at each scl_p, so the MSB is received first.
REQ-023 The bit counter advances on each scl_p in DATA; after the NBITS-th scl_p, the next scl_n enters ACK.
REQ-024 ACK, write: release SDA and sample sda_in at scl_p; ack_err equals the sampled value.
REQ-025 ACK, read: drive sda_oe = ~cmd_nack from the entering scl_n; ack_err is 0.
REQ-026 STOP sequence:
- At the scl_n ending ACK, set sda_oe=1.
- At the next scl_p, set scl_en=0.
- At the following scl_p, set sda_oe=0 (SDA rises while SCL is high), pulse done and enter IDLE.
REQ-027 With no STOP, done pulses at the scl_n ending ACK; scl_en stays 1 and SCL keeps running (bus held).
REQ-028 No state change or sda_oe change occurs in a cycle with neither scl_p nor scl_n, except accept in IDLE.
REQ-029 If scl_p and scl_n are both 1 in the same cycle (illegal input), the block ignores both.
REQ-030 cmd_ready is 0 during the done cycle; the earliest next accept is the cycle after done.

Reset
REQ-031 While rst_n=0 at a clk edge: state=IDLE, sda_oe=0, scl_en=0, done=0, ack_err=0, rx_data=0, bit counter=0, busy=0.
REQ-032 Reset asserted mid-transfer aborts the transfer immediately, releases both lines, and produces no done pulse.

Structure
REQ-033 A shared package i2c_pkg holds the state enumeration (IDLE, START, DATA, ACK, STOP) and the default NBITS constant.
REQ-034 The block is a single module with no sub-modules; i2c_div_clk is instantiated alongside it at the top level, not inside it.

Verification
REQ-035 Directed scenarios the bench SHALL cover:
- Write 0xA5 with start and stop, slave ACKs -> SDA bits 1,0,1,0,0,1,0,1 at successive scl_p; then done=1, ack_err=0, SCL and SDA released high.
- Write 0x3C, slave NACKs (sda_in=1 in ACK) -> done with ack_err=1.
- Read with cmd_nack=1, slave drives 0x5A -> rx_data=0x5A at done; sda_oe=0 during ACK.
- Back-to-back: write without stop, then a new command on the cycle after done -> cmd_ready=0 during done; second byte continues with scl_en held 1.
- rst_n=0 during bit 4 of DATA -> next cycle sda_oe=0, scl_en=0, busy=0; no done pulse.
- scl_p and scl_n both 1 in one cycle -> state and sda_oe unchanged.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared definitions for the byte-level I2C master: controller states and
// the default byte width.
package i2c_pkg;

   localparam int NBITS_DEFAULT = 8;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      ACK,
      STOP
   } i2c_state_e;

endpackage

// File: rtl/i2c_master_byte_if.sv
// Command handshake, result and bus-pin bundle of the byte-level I2C master.
// The master modport is the controller's view; slave is the host/bus side.
interface i2c_master_byte_if #(
   parameter int NBITS = i2c_pkg::NBITS_DEFAULT
);

   logic             scl_p;
   logic             scl_n;
   logic             cmd_valid;
   logic             cmd_ready;
   logic             cmd_start;
   logic             cmd_stop;
   logic             cmd_read;
   logic             cmd_nack;
   logic [NBITS-1:0] tx_data;
   logic [NBITS-1:0] rx_data;
   logic             sda_in;
   logic             sda_oe;
   logic             scl_en;
   logic             done;
   logic             ack_err;
   logic             busy;

   modport master (
      input  scl_p, scl_n, cmd_valid, cmd_start, cmd_stop, cmd_read, cmd_nack,
             tx_data, sda_in,
      output cmd_ready, rx_data, sda_oe, scl_en, done, ack_err, busy
   );

   modport slave (
      output scl_p, scl_n, cmd_valid, cmd_start, cmd_stop, cmd_read, cmd_nack,
             tx_data, sda_in,
      input  cmd_ready, rx_data, sda_oe, scl_en, done, ack_err, busy
   );

endinterface

// File: rtl/i2c_master_byte.sv
// Byte-level I2C master: transfers one byte with optional START/STOP framing,
// paced by SCL rise/fall strobes from a divider running on the same clk.
module i2c_master_byte
   import i2c_pkg::*;
#(
   parameter int NBITS = NBITS_DEFAULT
) (
   input  logic              clk,
   input  logic              rst_n,
   i2c_master_byte_if.master bus
);

   localparam int            CW       = $clog2(NBITS + 1);
   localparam logic [CW-1:0] LAST_BIT = CW'(NBITS);

   i2c_state_e       state_q,   state_d;
   logic             phase_q,   phase_d;
   logic             armed_q,   armed_d;
   logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
   logic [NBITS-1:0] tx_q,      tx_d;
   logic [NBITS-1:0] rx_q,      rx_d;
   logic             rd_q,      rd_d;
   logic             stop_q,    stop_d;
   logic             nack_q,    nack_d;
   logic             ack_smp_q, ack_smp_d;
   logic             sda_oe_q,  sda_oe_d;
   logic             scl_en_q,  scl_en_d;
   logic             done_q,    done_d;
   logic             ack_err_q, ack_err_d;

   logic p, n, ready, accept;

   // Coincident strobes are illegal input and are dropped entirely.
   assign p      = bus.scl_p & ~bus.scl_n;
   assign n      = bus.scl_n & ~bus.scl_p;
   assign ready  = (state_q == IDLE) && !done_q;
   assign accept = bus.cmd_valid && ready;

   assign bus.cmd_ready = ready;
   assign bus.rx_data   = rx_q;
   assign bus.sda_oe    = sda_oe_q;
   assign bus.scl_en    = scl_en_q;
   assign bus.done      = done_q;
   assign bus.ack_err   = ack_err_q;
   assign bus.busy      = (state_q != IDLE);

   always_comb begin
      // NOTE: every next-state value starts from its hold value so no branch can infer a latch.
      state_d   = state_q;
      phase_d   = phase_q;
      armed_d   = armed_q;
      bit_cnt_d = bit_cnt_q;
      tx_d      = tx_q;
      rx_d      = rx_q;
      rd_d      = rd_q;
      stop_d    = stop_q;
      nack_d    = nack_q;
      ack_smp_d = ack_smp_q;
      sda_oe_d  = sda_oe_q;
      scl_en_d  = scl_en_q;
      ack_err_d = ack_err_q;
      done_d    = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (accept) begin
               tx_d      = bus.tx_data;
               rd_d      = bus.cmd_read;
               stop_d    = bus.cmd_stop;
               nack_d    = bus.cmd_nack;
               ack_smp_d = 1'b0;
               bit_cnt_d = '0;
               armed_d   = 1'b0;
               phase_d   = 1'b0;
               state_d   = bus.cmd_start ? START : DATA;
            end
         end

         // phase_q: START has pulled SDA low (START) / SCL already parked (STOP).
         START: begin
            if (!phase_q && p) begin
               sda_oe_d = 1'b1;
               phase_d  = 1'b1;
            end else if (phase_q && n) begin
               scl_en_d = 1'b1;
               sda_oe_d = rd_q ? 1'b0 : ~tx_q[NBITS-1];
               tx_d     = {tx_q[NBITS-2:0], 1'b0};
               armed_d  = 1'b1;
               state_d  = DATA;
            end
         end

         // Without START, SCL may rise before the first bit is placed; armed_q
         // keeps that rising edge from counting as a data bit.
         DATA: begin
            if (n) begin
               if (bit_cnt_q == LAST_BIT) begin
                  sda_oe_d = rd_q ? ~nack_q : 1'b0;
                  state_d  = ACK;
               end else begin
                  scl_en_d = 1'b1;
                  sda_oe_d = rd_q ? 1'b0 : ~tx_q[NBITS-1];
                  tx_d     = {tx_q[NBITS-2:0], 1'b0};
                  armed_d  = 1'b1;
               end
            end else if (p && armed_q && (bit_cnt_q != LAST_BIT)) begin
               bit_cnt_d = bit_cnt_q + CW'(1);
               if (rd_q) begin
                  rx_d = {rx_q[NBITS-2:0], bus.sda_in};
               end
            end
         end

         ACK: begin
            if (p && !rd_q) begin
               ack_smp_d = bus.sda_in;
            end else if (n) begin
               if (stop_q) begin
                  sda_oe_d = 1'b1;
                  phase_d  = 1'b0;
                  state_d  = STOP;
               end else begin
                  sda_oe_d  = 1'b0;
                  done_d    = 1'b1;
                  ack_err_d = ack_smp_q;
                  state_d   = IDLE;
               end
            end
         end

         STOP: begin
            if (p) begin
               if (!phase_q) begin
                  scl_en_d = 1'b0;
                  phase_d  = 1'b1;
               end else begin
                  sda_oe_d  = 1'b0;
                  done_d    = 1'b1;
                  ack_err_d = ack_smp_q;
                  state_d   = IDLE;
               end
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!rst_n) begin
         state_q   <= IDLE;
         phase_q   <= 1'b0;
         armed_q   <= 1'b0;
         bit_cnt_q <= '0;
         tx_q      <= '0;
         rx_q      <= '0;
         rd_q      <= 1'b0;
         stop_q    <= 1'b0;
         nack_q    <= 1'b0;
         ack_smp_q <= 1'b0;
         sda_oe_q  <= 1'b0;
         scl_en_q  <= 1'b0;
         done_q    <= 1'b0;
         ack_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         phase_q   <= phase_d;
         armed_q   <= armed_d;
         bit_cnt_q <= bit_cnt_d;
         tx_q      <= tx_d;
         rx_q      <= rx_d;
         rd_q      <= rd_d;
         stop_q    <= stop_d;
         nack_q    <= nack_d;
         ack_smp_q <= ack_smp_d;
         sda_oe_q  <= sda_oe_d;
         scl_en_q  <= scl_en_d;
         done_q    <= done_d;
         ack_err_q <= ack_err_d;
      end
   end

endmodule

// File: tb/tb_i2c_master_byte.sv
// Bench for i2c_master_byte: strobe generator, open-drain SDA line and a
// byte-level slave model; expectations come from the command and slave data.
module tb_i2c_master_byte;

   localparam int NB  = 8;
   localparam int DIV = 8;

   logic clk = 1'b0;
   logic rst_n;

   i2c_master_byte_if #(.NBITS(NB)) bus ();

   i2c_master_byte #(.NBITS(NB)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_pass = 0;
   int n_chk  = 0;

   int          ph = 0;
   bit          inj_req = 1'b0;
   int          inj_bit = 0;
   bit          inj_fired = 1'b0;

   bit          sl_active = 1'b0;
   bit          sl_seen_n = 1'b0;
   bit          sl_read = 1'b0;
   bit          sl_nack = 1'b0;
   logic [NB-1:0] sl_byte = '0;
   int          sl_cnt = 0;
   logic        sl_low = 1'b0;

   logic [NB-1:0] cap_bits;
   logic        cap_ack_oe;
   bit          acc_seen = 1'b0;

   int          done_cnt = 0;
   logic        d_ack_err, d_scl_en, d_sda_oe, d_ready, d_busy;
   logic [NB-1:0] d_rx;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp)
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      else
         n_pass++;
   endtask

   // One clk cycle: record results of the edge just passed, then set the
   // strobes and slave drive for the next edge.
   task automatic tick();
      bit acc;
      bit sp;
      bit sn;
      acc = bus.cmd_valid && bus.cmd_ready && rst_n;
      @(negedge clk);
      acc_seen = acc;
      if (acc) begin
         sl_active  = 1'b1;
         sl_seen_n  = 1'b0;
         sl_cnt     = 0;
         sl_low     = 1'b0;
         cap_bits   = '0;
         cap_ack_oe = 1'bx;
      end
      if (bus.done === 1'b1) begin
         done_cnt++;
         d_ack_err = bus.ack_err;
         d_scl_en  = bus.scl_en;
         d_sda_oe  = bus.sda_oe;
         d_ready   = bus.cmd_ready;
         d_busy    = bus.busy;
         d_rx      = bus.rx_data;
         sl_active = 1'b0;
         sl_low    = 1'b0;
      end
      ph = (ph + 1) % DIV;
      sp = (ph == 0);
      sn = (ph == DIV / 2);
      if (inj_req && sl_active && sl_cnt == inj_bit && ph == DIV / 2 + 2) begin
         sp = 1'b1;
         sn = 1'b1;
         inj_req   = 1'b0;
         inj_fired = 1'b1;
      end
      if (sl_active && !(sp && sn)) begin
         if (sn) begin
            sl_seen_n = 1'b1;
            if (sl_read)
               sl_low = (sl_cnt < NB) ? ~sl_byte[NB-1-sl_cnt] : 1'b0;
            else
               sl_low = (sl_cnt == NB) ? ~sl_nack : 1'b0;
         end
         if (sp && sl_seen_n && bus.scl_en === 1'b1 && sl_cnt <= NB) begin
            if (sl_cnt < NB)
               cap_bits = {cap_bits[NB-2:0], ~(bus.sda_oe | sl_low)};
            else
               cap_ack_oe = bus.sda_oe;
            sl_cnt++;
         end
      end
      bus.scl_p  = sp;
      bus.scl_n  = sn;
      bus.sda_in = ~(bus.sda_oe | sl_low);
   endtask

   task automatic issue(input bit start, input bit stop, input bit rd, input bit nack,
                        input logic [NB-1:0] tx, output bit ok);
      int budget;
      bus.cmd_valid = 1'b1;
      bus.cmd_start = start;
      bus.cmd_stop  = stop;
      bus.cmd_read  = rd;
      bus.cmd_nack  = nack;
      bus.tx_data   = tx;
      budget = 0;
      do begin
         tick();
         budget++;
      end while (!acc_seen && budget < 50);
      check("accept", acc_seen, 1);
      ok = acc_seen;
      bus.cmd_valid = 1'b0;
      bus.cmd_start = 1'($urandom);
      bus.cmd_stop  = 1'($urandom);
      bus.cmd_read  = 1'($urandom);
      bus.cmd_nack  = 1'($urandom);
      bus.tx_data   = NB'($urandom);
   endtask

   task automatic run_cmd(input bit start, input bit stop, input bit rd, input bit nack,
                          input logic [NB-1:0] tx, input logic [NB-1:0] sbyte,
                          input bit snack, input int inj);
      int   base;
      int   budget;
      bit   ok;
      logic e_oe;
      logic e_ack_oe;
      logic e_ack_err;
      sl_read = rd;
      sl_byte = sbyte;
      sl_nack = snack;
      issue(start, stop, rd, nack, tx, ok);
      if (!ok) return;
      if (!start) check("scl_en_held", bus.scl_en, 1);
      if (inj > 0) begin
         inj_req = 1'b1;
         inj_bit = inj;
      end
      base   = done_cnt;
      budget = 0;
      while (done_cnt == base && budget < 400) begin
         tick();
         budget++;
         if (inj_fired) begin
            inj_fired = 1'b0;
            tick();
            e_oe = ~tx[NB-1-inj_bit];
            check("both_strobe_sda_oe", bus.sda_oe, e_oe);
            check("both_strobe_busy", bus.busy, 1);
         end
      end
      inj_req = 1'b0;
      check("done_pulse", done_cnt - base, 1);
      if (done_cnt == base) return;
      if (!rd) begin
         for (int i = 0; i < NB; i++)
            check($sformatf("wbit%0d", i), cap_bits[NB-1-i], tx[NB-1-i]);
      end else begin
         check("rx_data", d_rx, sbyte);
      end
      e_ack_oe  = rd ? !nack : 1'b0;
      e_ack_err = rd ? 1'b0 : snack;
      check("ack_sda_oe", cap_ack_oe, e_ack_oe);
      check("ack_err", d_ack_err, e_ack_err);
      check("ready_in_done", d_ready, 0);
      check("busy_in_done", d_busy, 0);
      check("scl_en_at_done", d_scl_en, !stop);
      check("sda_oe_at_done", d_sda_oe, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit held;
      bit ok;
      int base;
      int budget;
      bit st, sp_, rd, nk, snk;
      int inj;

      rst_n         = 1'b0;
      bus.scl_p     = 1'b0;
      bus.scl_n     = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.cmd_start = 1'b0;
      bus.cmd_stop  = 1'b0;
      bus.cmd_read  = 1'b0;
      bus.cmd_nack  = 1'b0;
      bus.tx_data   = '0;
      bus.sda_in    = 1'b1;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      check("rst_sda_oe", bus.sda_oe, 0);
      check("rst_scl_en", bus.scl_en, 0);
      check("rst_done", bus.done, 0);
      check("rst_ack_err", bus.ack_err, 0);
      check("rst_rx_data", bus.rx_data, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_cmd_ready", bus.cmd_ready, 1);

      // Directed scenarios.
      run_cmd(1, 1, 0, 0, 8'hA5, 8'h00, 0, 0);
      run_cmd(1, 1, 0, 0, 8'h3C, 8'h00, 1, 0);
      run_cmd(1, 1, 1, 1, 8'h00, 8'h5A, 0, 0);
      run_cmd(1, 0, 0, 0, 8'h96, 8'h00, 0, 0);
      run_cmd(0, 1, 1, 0, 8'h00, 8'hC3, 0, 0);
      run_cmd(1, 1, 0, 0, 8'h6B, 8'h00, 0, 3);

      // Reset during bit 4 of a write.
      sl_read = 1'b0;
      sl_nack = 1'b0;
      issue(1, 1, 0, 0, 8'hF0, ok);
      base   = done_cnt;
      budget = 0;
      while (ok && sl_cnt < 4 && budget < 300) begin
         tick();
         budget++;
      end
      check("reach_bit4", sl_cnt, 4);
      rst_n = 1'b0;
      tick();
      sl_active = 1'b0;
      sl_low    = 1'b0;
      check("midrst_sda_oe", bus.sda_oe, 0);
      check("midrst_scl_en", bus.scl_en, 0);
      check("midrst_busy", bus.busy, 0);
      check("midrst_done", bus.done, 0);
      rst_n = 1'b1;
      repeat (40) tick();
      check("midrst_no_done", done_cnt - base, 0);
      check("midrst_idle_scl_en", bus.scl_en, 0);

      // Randomized command sequence against the byte-level model.
      held = 1'b0;
      for (int i = 0; i < 24; i++) begin
         repeat ($urandom_range(0, 10)) tick();
         st  = !held;
         sp_ = (i == 23) ? 1'b1 : 1'($urandom);
         rd  = 1'($urandom);
         nk  = 1'($urandom);
         snk = 1'($urandom);
         inj = (!rd && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0;
         run_cmd(st, sp_, rd, nk, NB'($urandom), NB'($urandom), snk, inj);
         held = !sp_;
      end

      repeat (4) tick();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
